// File: rtl/axi_pkg.sv
// Shared encodings and FSM state types for the AXI RAM endpoint.
// Both IDLE states encode as zero so the debug state outputs read 0 in reset.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry read return buffer that hides the one-cycle RAM read latency.
// RAM data arriving into an empty buffer with READY high bypasses storage.
module axi_rd_skid (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue,
  input  logic        i_issue_last,
  input  logic [31:0] i_data,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_credit
);

  logic [31:0] r_buf_data [2];
  logic [1:0]  r_buf_last;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_pend;
  logic        r_pend_last;

  logic       w_empty;
  logic       w_push;
  logic       w_pop_buf;
  logic [1:0] w_occ;

  assign w_empty   = (r_count == 2'd0);
  assign w_push    = r_pend && !(w_empty && i_ready);
  assign w_pop_buf = !w_empty && i_ready;
  // Stored entries plus the read in flight never exceed the two slots.
  assign w_occ     = r_count + {1'b0, r_pend};
  assign o_credit  = (w_occ < 2'd2);
  assign o_valid   = !w_empty || r_pend;

  always_comb begin
    o_data = '0;
    o_last = 1'b0;
    if (!w_empty) begin
      o_data = r_buf_data[r_rd_ptr];
      o_last = r_buf_last[r_rd_ptr];
    end else if (r_pend) begin
      o_data = i_data;
      o_last = r_pend_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend        <= 1'b0;
      r_pend_last   <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_buf_last    <= 2'b00;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
    end else begin
      r_pend      <= i_issue;
      r_pend_last <= i_issue_last;
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= i_data;
        r_buf_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop_buf) r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop_buf)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop_buf) r_count <= r_count - 2'd1;
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI slave terminating in a byte-strobed word RAM; independent write and read
// engines, one burst outstanding each, SLVERR for WRAP/reserved or malformed bursts.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int MEM_AW   = 10
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
  input  logic [31:0]         SLAVE_WR_ADDR,
  input  logic [7:0]          SLAVE_WR_ADDR_LEN,
  input  logic [1:0]          SLAVE_WR_ADDR_BURST,
  input  logic                SLAVE_WR_ADDR_VALID,
  output logic                SLAVE_WR_ADDR_READY,
  input  logic [31:0]         SLAVE_WR_DATA,
  input  logic [3:0]          SLAVE_WR_STRB,
  input  logic                SLAVE_WR_DATA_LAST,
  input  logic                SLAVE_WR_DATA_VALID,
  output logic                SLAVE_WR_DATA_READY,
  output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
  output logic [1:0]          SLAVE_WR_BACK_RESP,
  output logic                SLAVE_WR_BACK_VALID,
  input  logic                SLAVE_WR_BACK_READY,
  input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
  input  logic [31:0]         SLAVE_RD_ADDR,
  input  logic [7:0]          SLAVE_RD_ADDR_LEN,
  input  logic [1:0]          SLAVE_RD_ADDR_BURST,
  input  logic                SLAVE_RD_ADDR_VALID,
  output logic                SLAVE_RD_ADDR_READY,
  output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
  output logic [31:0]         SLAVE_RD_DATA,
  output logic [1:0]          SLAVE_RD_DATA_RESP,
  output logic                SLAVE_RD_DATA_LAST,
  output logic                SLAVE_RD_DATA_VALID,
  input  logic                SLAVE_RD_DATA_READY,
  output logic [1:0]          DBG_WR_STATE,
  output logic                DBG_RD_STATE
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
  // VALID never waits on READY, and a stalled VALID holds its payload stable.
  localparam int DEPTH = 1 << MEM_AW;

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;

  logic                r_aw_ready, r_w_ready, r_b_valid, r_ar_ready;
  logic [ID_WIDTH-1:0] r_wr_id, r_rd_id;
  logic [MEM_AW-1:0]   r_wr_idx, r_rd_idx;
  logic [7:0]          r_wr_len, r_rd_len, r_wr_beat, r_rd_beat;
  logic [1:0]          r_wr_burst, r_rd_burst, r_wr_resp, r_rd_resp;
  logic                r_wr_ovf, r_rd_done;

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_we, w_issue;
  logic [31:0] w_ram_q, w_rd_fill;
  logic        w_sk_valid, w_sk_last, w_credit;
  logic        w_unused_addr_bits;

  assign w_aw_hs = SLAVE_WR_ADDR_VALID && r_aw_ready;
  assign w_w_hs  = SLAVE_WR_DATA_VALID && r_w_ready;
  assign w_b_hs  = r_b_valid && SLAVE_WR_BACK_READY;
  assign w_ar_hs = SLAVE_RD_ADDR_VALID && r_ar_ready;
  assign w_r_hs  = w_sk_valid && SLAVE_RD_DATA_READY;
  assign w_we    = w_w_hs && burst_ok(r_wr_burst);
  assign w_issue = (r_rd_state == R_DATA) && !r_rd_done && w_credit;

  always_comb begin
    w_wr_next = r_wr_state;
    unique case (r_wr_state)
      W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
      W_DATA:  if (w_w_hs && SLAVE_WR_DATA_LAST) w_wr_next = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so reset drives them low.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_wr_state <= W_IDLE;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_wr_id    <= '0;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_burst <= '0;
      r_wr_beat  <= '0;
      r_wr_resp  <= '0;
      r_wr_ovf   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_aw_ready <= (w_wr_next == W_IDLE);
      r_w_ready  <= (w_wr_next == W_DATA);
      r_b_valid  <= (w_wr_next == W_RESP);
      if (w_aw_hs) begin
        r_wr_id    <= SLAVE_WR_ADDR_ID;
        r_wr_idx   <= SLAVE_WR_ADDR[MEM_AW+1:2];
        r_wr_len   <= SLAVE_WR_ADDR_LEN;
        r_wr_burst <= SLAVE_WR_ADDR_BURST;
        r_wr_beat  <= '0;
        r_wr_ovf   <= 1'b0;
      end
      if (w_w_hs) begin
        r_wr_beat <= r_wr_beat + 8'd1;
        if (r_wr_burst == BURST_INCR) r_wr_idx <= r_wr_idx + MEM_AW'(1);
        if (!SLAVE_WR_DATA_LAST && (r_wr_beat == r_wr_len)) r_wr_ovf <= 1'b1;
        if (SLAVE_WR_DATA_LAST)
          r_wr_resp <= (burst_ok(r_wr_burst) && !r_wr_ovf && (r_wr_beat == r_wr_len))
                       ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_next = R_DATA;
      R_DATA:  if (w_r_hs && w_sk_last) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_rd_state <= R_IDLE;
      r_ar_ready <= 1'b0;
      r_rd_id    <= '0;
      r_rd_idx   <= '0;
      r_rd_len   <= '0;
      r_rd_burst <= '0;
      r_rd_beat  <= '0;
      r_rd_resp  <= '0;
      r_rd_done  <= 1'b0;
    end else begin
      r_rd_state <= w_rd_next;
      r_ar_ready <= (w_rd_next == R_IDLE);
      if (w_ar_hs) begin
        r_rd_id    <= SLAVE_RD_ADDR_ID;
        r_rd_idx   <= SLAVE_RD_ADDR[MEM_AW+1:2];
        r_rd_len   <= SLAVE_RD_ADDR_LEN;
        r_rd_burst <= SLAVE_RD_ADDR_BURST;
        r_rd_beat  <= '0;
        r_rd_done  <= 1'b0;
        r_rd_resp  <= burst_ok(SLAVE_RD_ADDR_BURST) ? RESP_OKAY : RESP_SLVERR;
      end else if (w_issue) begin
        r_rd_beat <= r_rd_beat + 8'd1;
        if (r_rd_burst == BURST_INCR) r_rd_idx <= r_rd_idx + MEM_AW'(1);
        if (r_rd_beat == r_rd_len) r_rd_done <= 1'b1;
      end
    end
  end

  // Byte lanes: the registered read samples the array before this edge's write.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;
    always_ff @(posedge BUS_CLK) begin
      if (w_we && SLAVE_WR_STRB[b]) r_mem[r_wr_idx] <= SLAVE_WR_DATA[8*b +: 8];
      if (w_issue) r_q <= r_mem[r_rd_idx];
    end
    assign w_ram_q[8*b +: 8] = r_q;
  end

  assign w_rd_fill = (r_rd_resp == RESP_SLVERR) ? '0 : w_ram_q;

  axi_rd_skid u_skid (
    .i_clk        (BUS_CLK),
    .i_rst        (BUS_RST),
    .i_issue      (w_issue),
    .i_issue_last (r_rd_beat == r_rd_len),
    .i_data       (w_rd_fill),
    .i_ready      (SLAVE_RD_DATA_READY),
    .o_valid      (w_sk_valid),
    .o_data       (SLAVE_RD_DATA),
    .o_last       (w_sk_last),
    .o_credit     (w_credit)
  );

  assign SLAVE_WR_ADDR_READY = r_aw_ready;
  assign SLAVE_WR_DATA_READY = r_w_ready;
  assign SLAVE_WR_BACK_VALID = r_b_valid;
  assign SLAVE_WR_BACK_ID    = r_wr_id;
  assign SLAVE_WR_BACK_RESP  = r_wr_resp;
  assign SLAVE_RD_ADDR_READY = r_ar_ready;
  assign SLAVE_RD_BACK_ID    = r_rd_id;
  assign SLAVE_RD_DATA_RESP  = r_rd_resp;
  assign SLAVE_RD_DATA_LAST  = w_sk_last;
  assign SLAVE_RD_DATA_VALID = w_sk_valid;
  assign DBG_WR_STATE        = r_wr_state;
  assign DBG_RD_STATE        = r_rd_state;

  assign w_unused_addr_bits = ^{SLAVE_WR_ADDR[31:MEM_AW+2], SLAVE_WR_ADDR[1:0],
                                SLAVE_RD_ADDR[31:MEM_AW+2], SLAVE_RD_ADDR[1:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: each test task drives one scenario and
// checks its own outputs against hand-computed values.
module tb_axi_ram_slave;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic [3:0]  SLAVE_WR_ADDR_ID;
  logic [31:0] SLAVE_WR_ADDR;
  logic [7:0]  SLAVE_WR_ADDR_LEN;
  logic [1:0]  SLAVE_WR_ADDR_BURST;
  logic        SLAVE_WR_ADDR_VALID;
  logic        SLAVE_WR_ADDR_READY;
  logic [31:0] SLAVE_WR_DATA;
  logic [3:0]  SLAVE_WR_STRB;
  logic        SLAVE_WR_DATA_LAST;
  logic        SLAVE_WR_DATA_VALID;
  logic        SLAVE_WR_DATA_READY;
  logic [3:0]  SLAVE_WR_BACK_ID;
  logic [1:0]  SLAVE_WR_BACK_RESP;
  logic        SLAVE_WR_BACK_VALID;
  logic        SLAVE_WR_BACK_READY;
  logic [3:0]  SLAVE_RD_ADDR_ID;
  logic [31:0] SLAVE_RD_ADDR;
  logic [7:0]  SLAVE_RD_ADDR_LEN;
  logic [1:0]  SLAVE_RD_ADDR_BURST;
  logic        SLAVE_RD_ADDR_VALID;
  logic        SLAVE_RD_ADDR_READY;
  logic [3:0]  SLAVE_RD_BACK_ID;
  logic [31:0] SLAVE_RD_DATA;
  logic [1:0]  SLAVE_RD_DATA_RESP;
  logic        SLAVE_RD_DATA_LAST;
  logic        SLAVE_RD_DATA_VALID;
  logic        SLAVE_RD_DATA_READY;
  logic [1:0]  DBG_WR_STATE;
  logic        DBG_RD_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [1:0]  got_resp[$];
  logic [3:0]  got_id[$];
  logic [31:0] exp_q[$];

  logic [52:0] all_out;
  assign all_out = {SLAVE_WR_ADDR_READY, SLAVE_WR_DATA_READY, SLAVE_WR_BACK_ID,
                    SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID, SLAVE_RD_ADDR_READY,
                    SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP,
                    SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID, DBG_WR_STATE, DBG_RD_STATE};

  axi_ram_slave #(.ID_WIDTH(4), .MEM_AW(10)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
    .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
    .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
    .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
    .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
    .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
    .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
    .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY),
    .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR),
    .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN), .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST),
    .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID), .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
    .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA),
    .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP), .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST),
    .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID), .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY),
    .DBG_WR_STATE(DBG_WR_STATE), .DBG_RD_STATE(DBG_RD_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 BUS_CLK = ~BUS_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  task automatic idle_inputs;
    SLAVE_WR_ADDR_ID = '0; SLAVE_WR_ADDR = '0; SLAVE_WR_ADDR_LEN = '0;
    SLAVE_WR_ADDR_BURST = '0; SLAVE_WR_ADDR_VALID = 1'b0;
    SLAVE_WR_DATA = '0; SLAVE_WR_STRB = '0; SLAVE_WR_DATA_LAST = 1'b0;
    SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_BACK_READY = 1'b0;
    SLAVE_RD_ADDR_ID = '0; SLAVE_RD_ADDR = '0; SLAVE_RD_ADDR_LEN = '0;
    SLAVE_RD_ADDR_BURST = '0; SLAVE_RD_ADDR_VALID = 1'b0; SLAVE_RD_DATA_READY = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int cyc = 0;
    SLAVE_WR_ADDR_ID = id; SLAVE_WR_ADDR = addr; SLAVE_WR_ADDR_LEN = len;
    SLAVE_WR_ADDR_BURST = burst; SLAVE_WR_ADDR_VALID = 1'b1;
    @(negedge BUS_CLK);
    while (!SLAVE_WR_ADDR_READY && cyc < 50) begin @(negedge BUS_CLK); cyc++; end
    if (cyc >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout: awready stayed 0, required 1");
    end
    @(posedge BUS_CLK); #1;
    SLAVE_WR_ADDR_VALID = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int cyc = 0;
    SLAVE_RD_ADDR_ID = id; SLAVE_RD_ADDR = addr; SLAVE_RD_ADDR_LEN = len;
    SLAVE_RD_ADDR_BURST = burst; SLAVE_RD_ADDR_VALID = 1'b1;
    @(negedge BUS_CLK);
    while (!SLAVE_RD_ADDR_READY && cyc < 50) begin @(negedge BUS_CLK); cyc++; end
    if (cyc >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: arready stayed 0, required 1");
    end
    @(posedge BUS_CLK); #1;
    SLAVE_RD_ADDR_VALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int cyc = 0;
    SLAVE_WR_DATA = data; SLAVE_WR_STRB = strb; SLAVE_WR_DATA_LAST = last;
    SLAVE_WR_DATA_VALID = 1'b1;
    @(negedge BUS_CLK);
    while (!SLAVE_WR_DATA_READY && cyc < 50) begin @(negedge BUS_CLK); cyc++; end
    if (cyc >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL w_timeout: wready stayed 0, required 1");
    end
    @(posedge BUS_CLK); #1;
    SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_DATA_LAST = 1'b0;
  endtask

  task automatic b_wait(output logic [1:0] resp, output logic [3:0] id);
    int cyc = 0;
    SLAVE_WR_BACK_READY = 1'b1;
    @(negedge BUS_CLK);
    while (!SLAVE_WR_BACK_VALID && cyc < 50) begin @(negedge BUS_CLK); cyc++; end
    if (cyc >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL b_timeout: bvalid stayed 0, required 1");
    end
    resp = SLAVE_WR_BACK_RESP; id = SLAVE_WR_BACK_ID;
    @(posedge BUS_CLK); #1;
    SLAVE_WR_BACK_READY = 1'b0;
  endtask

  // Collects n beats; counts any stalled beat whose payload changed before acceptance.
  task automatic r_collect(input int n, input bit rnd, output int unstable);
    int cyc = 0;
    logic held = 1'b0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    got_data.delete(); got_last.delete(); got_resp.delete(); got_id.delete();
    unstable = 0;
    while (got_data.size() < n && cyc < 400) begin
      SLAVE_RD_DATA_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge BUS_CLK);
      if (held && (!SLAVE_RD_DATA_VALID || SLAVE_RD_DATA !== hd || SLAVE_RD_DATA_LAST !== hl))
        unstable++;
      held = 1'b0;
      if (SLAVE_RD_DATA_VALID) begin
        if (SLAVE_RD_DATA_READY) begin
          got_data.push_back(SLAVE_RD_DATA); got_last.push_back(SLAVE_RD_DATA_LAST);
          got_resp.push_back(SLAVE_RD_DATA_RESP); got_id.push_back(SLAVE_RD_BACK_ID);
        end else begin
          held = 1'b1; hd = SLAVE_RD_DATA; hl = SLAVE_RD_DATA_LAST;
        end
      end
      @(posedge BUS_CLK); #1;
      cyc++;
    end
    SLAVE_RD_DATA_READY = 1'b0;
    if (cyc >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL r_timeout: got %0d beats, required %0d", got_data.size(), n);
    end
    while (got_data.size() < n) begin
      got_data.push_back('x); got_last.push_back(1'bx);
      got_resp.push_back('x); got_id.push_back('x);
    end
  endtask

  task automatic wr_single(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic [3:0] id;
    aw_send(4'h1, addr, 8'd0, 2'b01);
    w_send(data, strb, 1'b1);
    b_wait(resp, id);
  endtask

  task automatic rd_word(input logic [31:0] addr, output logic [31:0] data);
    int unst;
    ar_send(4'h2, addr, 8'd0, 2'b01);
    r_collect(1, 1'b0, unst);
    data = got_data[0];
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset;
    idle_inputs();
    BUS_RST = 1'b1;
    repeat (3) @(posedge BUS_CLK);
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    BUS_RST = 1'b0;
    @(posedge BUS_CLK); #1;
    n_checks++;
    if (SLAVE_WR_ADDR_READY !== 1'b1 || SLAVE_RD_ADDR_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got aw=%b ar=%b, required 1 1",
               SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY);
    end
  endtask

  task automatic test_incr;
    logic [1:0] resp; logic [3:0] id; int unst;
    aw_send(4'h5, 32'h40, 8'd3, 2'b01);
    n_checks++;
    if (SLAVE_WR_DATA_READY !== 1'b1) begin
      n_fail++; $display("FAIL incr_wready_cycle1: got %b, required 1", SLAVE_WR_DATA_READY);
    end
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    n_checks++;
    if (SLAVE_WR_BACK_VALID !== 1'b1) begin
      n_fail++; $display("FAIL incr_bvalid_n1: got %b, required 1", SLAVE_WR_BACK_VALID);
    end
    b_wait(resp, id);
    n_checks++;
    if (resp !== 2'b00 || id !== 4'h5) begin
      n_fail++; $display("FAIL incr_bresp: got resp=%b id=%h, required 00 5", resp, id);
    end
    n_checks++;
    if (SLAVE_WR_ADDR_READY !== 1'b1) begin
      n_fail++; $display("FAIL incr_awready_after_b: got %b, required 1", SLAVE_WR_ADDR_READY);
    end
    ar_send(4'hA, 32'h40, 8'd3, 2'b01);
    n_checks++;
    if (SLAVE_RD_DATA_VALID !== 1'b0) begin
      n_fail++; $display("FAIL incr_rvalid_cycle1: got %b, required 0", SLAVE_RD_DATA_VALID);
    end
    @(posedge BUS_CLK); #1;
    n_checks++;
    if (SLAVE_RD_DATA_VALID !== 1'b1) begin
      n_fail++; $display("FAIL incr_rvalid_cycle2: got %b, required 1", SLAVE_RD_DATA_VALID);
    end
    r_collect(4, 1'b0, unst);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== 32'(i + 1) || got_last[i] !== (i == 3) || got_resp[i] !== 2'b00
          || got_id[i] !== 4'hA) begin
        n_fail++;
        $display("FAIL incr_rbeat%0d: got data=%h last=%b resp=%b id=%h, required %h %b 00 a",
                 i, got_data[i], got_last[i], got_resp[i], got_id[i], i + 1, i == 3);
      end
    end
    n_checks++;
    if (SLAVE_RD_ADDR_READY !== 1'b1) begin
      n_fail++; $display("FAIL incr_arready_after_last: got %b, required 1", SLAVE_RD_ADDR_READY);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] resp; logic [31:0] d;
    wr_single(32'h0, 32'h0000_0000, 4'hF, resp);
    wr_single(32'h0, 32'hAABB_CCDD, 4'h5, resp);
    rd_word(32'h0, d);
    n_checks++;
    if (d !== 32'h00BB_00DD) begin
      n_fail++; $display("FAIL strobe_merge: got %h, required 00bb00dd", d);
    end
  endtask

  task automatic test_fixed_and_wrap;
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; int unst;
    aw_send(4'h3, 32'h10, 8'd2, 2'b00);
    w_send(32'd7, 4'hF, 1'b0); w_send(32'd8, 4'hF, 1'b0); w_send(32'd9, 4'hF, 1'b1);
    b_wait(resp, id);
    rd_word(32'h10, d);
    n_checks++;
    if (resp !== 2'b00 || d !== 32'd9) begin
      n_fail++; $display("FAIL fixed_burst: got resp=%b data=%h, required 00 9", resp, d);
    end
    aw_send(4'h4, 32'hFFC, 8'd1, 2'b01);
    w_send(32'h1111_1111, 4'hF, 1'b0); w_send(32'h2222_2222, 4'hF, 1'b1);
    b_wait(resp, id);
    ar_send(4'h6, 32'hFFC, 8'd1, 2'b01);
    r_collect(2, 1'b0, unst);
    n_checks++;
    if (got_data[0] !== 32'h1111_1111 || got_data[1] !== 32'h2222_2222 || !got_last[1]) begin
      n_fail++; $display("FAIL wrap_read: got %h %h, required 11111111 22222222",
                         got_data[0], got_data[1]);
    end
    rd_word(32'h1000, d);
    n_checks++;
    if (d !== 32'h2222_2222) begin
      n_fail++; $display("FAIL upper_bits_ignored: got %h, required 22222222", d);
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; int unst;
    aw_send(4'h7, 32'h40, 8'd1, 2'b10);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b0); w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_wait(resp, id);
    n_checks++;
    if (resp !== 2'b10 || id !== 4'h7) begin
      n_fail++; $display("FAIL wrap_write_resp: got %b id=%h, required 10 7", resp, id);
    end
    rd_word(32'h40, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++; $display("FAIL wrap_write_mem: got %h, required 1", d);
    end
    aw_send(4'h8, 32'h80, 8'd3, 2'b01);
    w_send(32'h1, 4'hF, 1'b0); w_send(32'h2, 4'hF, 1'b1);
    n_checks++;
    if (SLAVE_WR_BACK_VALID !== 1'b1 || SLAVE_WR_BACK_RESP !== 2'b10) begin
      n_fail++; $display("FAIL early_last: got bvalid=%b resp=%b, required 1 10",
                         SLAVE_WR_BACK_VALID, SLAVE_WR_BACK_RESP);
    end
    b_wait(resp, id);
    ar_send(4'h9, 32'h40, 8'd2, 2'b11);
    r_collect(3, 1'b0, unst);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_data[i] !== 32'h0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL err_read_beat%0d: got data=%h resp=%b last=%b, required 0 10 %b",
                           i, got_data[i], got_resp[i], got_last[i], i == 2);
      end
    end
  endtask

  task automatic test_read_stall;
    logic [1:0] resp; logic [3:0] id; int unst;
    aw_send(4'h2, 32'h100, 8'd7, 2'b01);
    for (int i = 0; i < 8; i++) w_send(32'h100 + 32'(i), 4'hF, i == 7);
    b_wait(resp, id);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
    ar_send(4'hC, 32'h100, 8'd7, 2'b01);
    r_collect(8, 1'b1, unst);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (got_data[i] !== e || got_last[i] !== (i == 7)) begin
        n_fail++; $display("FAIL stall_beat%0d: got %h last=%b, required %h %b",
                           i, got_data[i], got_last[i], e, i == 7);
      end
    end
    n_checks++;
    if (unst !== 0) begin
      n_fail++; $display("FAIL stall_stability: got %0d changes under stall, required 0", unst);
    end
  endtask

  task automatic test_read_first;
    logic [1:0] resp; logic [3:0] id; logic [31:0] d;
    wr_single(32'h200, 32'h55, 4'hF, resp);
    SLAVE_WR_ADDR_ID = 4'h1; SLAVE_WR_ADDR = 32'h200; SLAVE_WR_ADDR_LEN = 8'd0;
    SLAVE_WR_ADDR_BURST = 2'b01; SLAVE_WR_ADDR_VALID = 1'b1;
    SLAVE_RD_ADDR_ID = 4'hD; SLAVE_RD_ADDR = 32'h200; SLAVE_RD_ADDR_LEN = 8'd0;
    SLAVE_RD_ADDR_BURST = 2'b01; SLAVE_RD_ADDR_VALID = 1'b1;
    @(negedge BUS_CLK);
    n_checks++;
    if (SLAVE_WR_ADDR_READY !== 1'b1 || SLAVE_RD_ADDR_READY !== 1'b1) begin
      n_fail++; $display("FAIL rf_addr_ready: got aw=%b ar=%b, required 1 1",
                         SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY);
    end
    @(posedge BUS_CLK); #1;
    SLAVE_WR_ADDR_VALID = 1'b0; SLAVE_RD_ADDR_VALID = 1'b0;
    SLAVE_WR_DATA = 32'h66; SLAVE_WR_STRB = 4'hF; SLAVE_WR_DATA_LAST = 1'b1;
    SLAVE_WR_DATA_VALID = 1'b1; SLAVE_RD_DATA_READY = 1'b1;
    @(posedge BUS_CLK); #1;
    SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_DATA_LAST = 1'b0;
    @(negedge BUS_CLK);
    n_checks++;
    if (SLAVE_RD_DATA_VALID !== 1'b1 || SLAVE_RD_DATA !== 32'h55) begin
      n_fail++; $display("FAIL read_first: got valid=%b data=%h, required 1 55",
                         SLAVE_RD_DATA_VALID, SLAVE_RD_DATA);
    end
    @(posedge BUS_CLK); #1;
    SLAVE_RD_DATA_READY = 1'b0;
    b_wait(resp, id);
    rd_word(32'h200, d);
    n_checks++;
    if (resp !== 2'b00 || d !== 32'h66) begin
      n_fail++; $display("FAIL rf_write_landed: got resp=%b data=%h, required 00 66", resp, d);
    end
  endtask

  task automatic test_reset_mid_read;
    int unst;
    ar_send(4'h3, 32'h100, 8'd7, 2'b01);
    SLAVE_RD_DATA_READY = 1'b1;
    repeat (3) begin @(posedge BUS_CLK); #1; end
    BUS_RST = 1'b1; SLAVE_RD_DATA_READY = 1'b0;
    @(posedge BUS_CLK); #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h, required 0", all_out);
    end
    BUS_RST = 1'b0;
    @(posedge BUS_CLK); #1;
    n_checks++;
    if (SLAVE_WR_ADDR_READY !== 1'b1 || SLAVE_RD_ADDR_READY !== 1'b1) begin
      n_fail++; $display("FAIL midreset_ready: got aw=%b ar=%b, required 1 1",
                         SLAVE_WR_ADDR_READY, SLAVE_RD_ADDR_READY);
    end
    ar_send(4'h4, 32'h100, 8'd7, 2'b01);
    r_collect(8, 1'b0, unst);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_data[i] !== 32'h100 + 32'(i) || got_last[i] !== (i == 7)) begin
        n_fail++; $display("FAIL midreset_ram_beat%0d: got %h last=%b, required %h %b",
                           i, got_data[i], got_last[i], 32'h100 + 32'(i), i == 7);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_fixed_and_wrap();
    test_errors();
    test_read_stall();
    test_read_first();
    test_reset_mid_read();
    repeat (2) @(posedge BUS_CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
